// File: rtl/pyjamask96_loader_if.sv
// Bus between the Pyjamask-96 block loader, its upstream block source and
// the downstream cipher core.
//
// Handshake: a block transfers on a rising clock edge where pt_valid and
// pt_ready are both 1. While pt_ready is 0 the loader ignores pt_valid and
// the block data. pt_data, key and reuse_key are only sampled on that
// transfer edge. pt_valid does not have to stay high until the transfer.
// core_valid is a level from the core. The loader looks at it only while it
// waits for the core to finish.
interface pyjamask96_loader_if;
    logic         pt_valid;
    logic         pt_ready;
    logic [95:0]  pt_data;
    logic [127:0] key;
    logic         reuse_key;
    logic         core_valid;
    logic         load;
    logic         load_key;
    logic         load_state;
    logic         start;
    logic [7:0]   byte_in;
    logic [7:0]   byte_key_in;

    // Environment side: the block source and the core status.
    modport master (
        output pt_valid, pt_data, key, reuse_key, core_valid,
        input  pt_ready, load, load_key, load_state, start, byte_in, byte_key_in
    );

    // Loader side.
    modport slave (
        input  pt_valid, pt_data, key, reuse_key, core_valid,
        output pt_ready, load, load_key, load_state, start, byte_in, byte_key_in
    );
endinterface

// File: rtl/pyjamask96_loader.sv
// Pyjamask-96 block loader.
// The loader accepts one plaintext block and key, then feeds them byte-serially to the
// cipher core. It pulses start, waits for the core's valid pulse to come and
// go, and then returns to idle. All outputs come straight from flops.
module pyjamask96_loader #(
    parameter int KEY_BYTES   = 16,
    parameter int STATE_BYTES = 12
) (
    input  logic                clk,
    input  logic                reset_n,   // active-high, asynchronous
    pyjamask96_loader_if.slave  bus,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        START  = 3'd3,
        WAIT_V = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    localparam logic [4:0] KEY_LAST = 5'(KEY_BYTES - 1);
    localparam logic [4:0] ST_LAST  = 5'(STATE_BYTES - 1);
    localparam logic [4:0] ST_N     = 5'(STATE_BYTES);

    state_t       state;
    logic [4:0]   idx;        // byte currently presented on the byte outputs
    logic [95:0]  pt_reg;
    logic [127:0] key_reg;
    logic         reuse_reg;

    logic [4:0]   nxt;
    logic [4:0]   last;

    // The FSM state is made visible so that checkers can bind to it.
    assign state_dbg = state;

    // Next byte index, and the last index of this block (key reuse ends after the state bytes).
    assign nxt  = idx + 5'd1;
    assign last = reuse_reg ? ST_LAST : KEY_LAST;

    // Key byte i, MSB first. Indices past the key yield zero.
    function automatic logic [7:0] key_byte(input logic [127:0] k, input logic [4:0] i);
        key_byte = 8'h00;
        for (int b = 0; b < 16; b++) begin
            if (i == 5'(b)) key_byte = k[127 - 8*b -: 8];
        end
    endfunction

    // Plaintext byte i, MSB first. Indices past the block yield zero.
    function automatic logic [7:0] pt_byte(input logic [95:0] p, input logic [4:0] i);
        pt_byte = 8'h00;
        for (int b = 0; b < 12; b++) begin
            if (i == 5'(b)) pt_byte = p[95 - 8*b -: 8];
        end
    endfunction

    // Control FSM. Each output is registered together with the state it belongs to.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state           <= IDLE;
            idx             <= 5'd0;
            pt_reg          <= '0;
            key_reg         <= '0;
            reuse_reg       <= 1'b0;
            bus.pt_ready    <= 1'b1;
            bus.load        <= 1'b0;
            bus.load_key    <= 1'b0;
            bus.load_state  <= 1'b0;
            bus.start       <= 1'b0;
            bus.byte_in     <= 8'h00;
            bus.byte_key_in <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pt_valid) begin
                        pt_reg       <= bus.pt_data;
                        key_reg      <= bus.key;
                        reuse_reg    <= bus.reuse_key;
                        bus.pt_ready <= 1'b0;
                        bus.load     <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    // Entering SHIFT: present byte 0 right away.
                    bus.load        <= 1'b0;
                    idx             <= 5'd0;
                    bus.load_key    <= !reuse_reg;
                    bus.byte_key_in <= reuse_reg ? 8'h00 : key_byte(key_reg, 5'd0);
                    bus.load_state  <= (5'd0 < ST_N);
                    bus.byte_in     <= pt_byte(pt_reg, 5'd0);
                    state           <= SHIFT;
                end
                SHIFT: begin
                    if (idx == last) begin
                        bus.load_key    <= 1'b0;
                        bus.load_state  <= 1'b0;
                        bus.byte_in     <= 8'h00;
                        bus.byte_key_in <= 8'h00;
                        bus.start       <= 1'b1;
                        state           <= START;
                    end else begin
                        idx             <= nxt;
                        bus.load_key    <= !reuse_reg;
                        bus.byte_key_in <= reuse_reg ? 8'h00 : key_byte(key_reg, nxt);
                        bus.load_state  <= (nxt < ST_N);
                        bus.byte_in     <= (nxt < ST_N) ? pt_byte(pt_reg, nxt) : 8'h00;
                    end
                end
                START: begin
                    bus.start <= 1'b0;
                    state     <= WAIT_V;
                end
                WAIT_V: begin
                    if (bus.core_valid) state <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.core_valid) begin
                        bus.pt_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    bus.pt_ready    <= 1'b1;
                    bus.load        <= 1'b0;
                    bus.load_key    <= 1'b0;
                    bus.load_state  <= 1'b0;
                    bus.start       <= 1'b0;
                    bus.byte_in     <= 8'h00;
                    bus.byte_key_in <= 8'h00;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule
